// File: rtl/memseq_defs.sv
// memseq_defs: shared definitions for the mem_sequencer codebase slice.
//   - 3-bit FSM state encodings
//   - NOP instruction word loaded into the instruction register at reset
//   - memory direction encodings (MEM_RD / MEM_WR)
//   - helper that identifies the states which wait on the memory port
package memseq_defs;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_F_WAIT = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_D_REQ  = 3'd4;
  localparam logic [2:0] ST_D_WAIT = 3'd5;
  localparam logic [2:0] ST_COMMIT = 3'd6;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  // States in which the sequencer is waiting on the memory port
  function automatic logic is_mem_phase(input logic [2:0] st);
    return (st == ST_FETCH) || (st == ST_F_WAIT) ||
           (st == ST_D_REQ) || (st == ST_D_WAIT);
  endfunction

endpackage

// File: rtl/memseq_timeout.sv
// memseq_timeout: per-phase wait counter for mem_sequencer.
//   clk     in  : clock
//   rst     in  : asynchronous active-low reset
//   clr     in  : synchronous clear (state change or retry)
//   en      in  : count this cycle
//   expired out : current cycle is the LIMIT-th consecutive counted cycle
module memseq_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_r;

  // Wait-cycle counter; clear has priority over counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // cnt_r holds the number of cycles already spent, so the LIMIT-th cycle
  // is the one where cnt_r == LIMIT-1
  assign expired = en && (cnt_r == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: multi-cycle controller that runs a single-cycle core over
// one shared variable-latency memory port (fetch -> optional data -> commit).
//
// Optional feature macro: MEMSEQ_TIMEOUT_EN
//   defined   : per-phase timeout; on expiry err_o is set (sticky) and the
//               sequencer retries the fetch at the unchanged PC
//   undefined : no counter, err_o stays 0, waits are unbounded
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   core_inst_addr_i       PC from the core
//   core_data_ce_i/we_i    load / store request from the core (both = store)
//   core_data_addr_i       load/store address
//   core_data_wdata_i      store data
//   core_inst_o            held instruction (NOP after reset)
//   core_data_rdata_o      held load data
//   core_en_o              one-cycle commit strobe
//   mem_req_o/we_o/addr_o/wdata_o   memory request (all zero when idle)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i   memory response
//   err_o                  sticky timeout flag
module mem_sequencer
  import memseq_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int WORD_BITWIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_BITWIDTH-1:0] core_inst_addr_i,
  input  logic                     core_data_ce_i,
  input  logic                     core_data_we_i,
  input  logic [WORD_BITWIDTH-1:0] core_data_addr_i,
  input  logic [WORD_BITWIDTH-1:0] core_data_wdata_i,
  output logic [WORD_BITWIDTH-1:0] core_inst_o,
  output logic [WORD_BITWIDTH-1:0] core_data_rdata_o,
  output logic                     core_en_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [WORD_BITWIDTH-1:0] mem_addr_o,
  output logic [WORD_BITWIDTH-1:0] mem_wdata_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [WORD_BITWIDTH-1:0] mem_rdata_i,
  output logic                     err_o
);

  logic [2:0]               state_r;
  logic [2:0]               next_state_s;
  logic [WORD_BITWIDTH-1:0] inst_r;
  logic [WORD_BITWIDTH-1:0] rdata_r;
  logic                     err_r;
  logic                     timeout_s;
  logic                     abort_s;
  logic                     is_data_s;
  logic                     is_store_s;

  // A simultaneous load+store request is handled as a store
  assign is_store_s = core_data_we_i;
  assign is_data_s  = core_data_ce_i | core_data_we_i;

`ifdef MEMSEQ_TIMEOUT_EN
  logic to_clr_s;

  // Retry (FETCH -> FETCH) is not a state change, so it clears explicitly
  assign to_clr_s = (next_state_s != state_r) | abort_s;

  memseq_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr_s),
    .en      (is_mem_phase(state_r)),
    .expired (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic; memory progress (grant/rvalid) wins over a timeout
  always_comb begin
    next_state_s = state_r;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        next_state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_gnt_i) begin
          next_state_s = ST_F_WAIT;
        end else if (timeout_s) begin
          next_state_s = ST_FETCH;
          abort_s      = 1'b1;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_F_WAIT: begin
        if (mem_rvalid_i) begin
          next_state_s = ST_EXEC;
        end else if (timeout_s) begin
          next_state_s = ST_FETCH;
          abort_s      = 1'b1;
        end else begin
          next_state_s = ST_F_WAIT;
        end
      end
      ST_EXEC: begin
        if (is_data_s) begin
          next_state_s = ST_D_REQ;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_D_REQ: begin
        if (mem_gnt_i) begin
          // a write is complete once granted
          if (is_store_s) begin
            next_state_s = ST_COMMIT;
          end else begin
            next_state_s = ST_D_WAIT;
          end
        end else if (timeout_s) begin
          next_state_s = ST_FETCH;
          abort_s      = 1'b1;
        end else begin
          next_state_s = ST_D_REQ;
        end
      end
      ST_D_WAIT: begin
        if (mem_rvalid_i) begin
          next_state_s = ST_COMMIT;
        end else if (timeout_s) begin
          next_state_s = ST_FETCH;
          abort_s      = 1'b1;
        end else begin
          next_state_s = ST_D_WAIT;
        end
      end
      ST_COMMIT: begin
        next_state_s = ST_FETCH;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register, instruction/data capture and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      inst_r  <= NOP_INST[WORD_BITWIDTH-1:0];
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_F_WAIT) && mem_rvalid_i) begin
        inst_r <= mem_rdata_i;
      end
      if ((state_r == ST_D_WAIT) && mem_rvalid_i) begin
        rdata_r <= mem_rdata_i;
      end
      if (abort_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Memory request and commit strobe decoded from the registered state so an
  // asynchronous reset removes them immediately; address/data are zero when
  // no request is active
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = MEM_RD;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    core_en_o   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req_o  = 1'b1;
        mem_we_o   = MEM_RD;
        mem_addr_o = core_inst_addr_i;
      end
      ST_EXEC: begin
        core_en_o = ~is_data_s;
      end
      ST_D_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = is_store_s ? MEM_WR : MEM_RD;
        mem_addr_o  = core_data_addr_i;
        mem_wdata_o = core_data_wdata_i;
      end
      ST_COMMIT: begin
        core_en_o = 1'b1;
      end
      default: begin
        core_en_o = 1'b0;
      end
    endcase
  end

  assign core_inst_o       = inst_r;
  assign core_data_rdata_o = rdata_r;
  assign err_o             = err_r;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: self-checking bench for mem_sequencer.
// The bench plays both the core (PC register, opcode decode of the held
// instruction) and the memory (randomised grant/rvalid delays), and checks
// each instruction against its expected bus transactions and cycle count.
module tb_mem_sequencer;

  localparam logic [6:0] OPC_ALU  = 7'b0110011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_BOTH = 7'b1111111;
  localparam int         TO_CYC   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] dwdata = 32'h0;
  logic        data_ce, data_we;
  logic [31:0] inst_o, rdata_o, mem_addr, mem_wdata;
  logic        en_o, mem_req, mem_we, err;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_inst = 32'h0000_0013;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  // Core model: decode of the held instruction's opcode
  assign data_ce = (inst_o[6:0] == OPC_LD) || (inst_o[6:0] == OPC_BOTH);
  assign data_we = (inst_o[6:0] == OPC_ST) || (inst_o[6:0] == OPC_BOTH);

  mem_sequencer #(
    .TIMEOUT_CYCLES (TO_CYC),
    .WORD_BITWIDTH  (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .core_inst_addr_i  (pc),
    .core_data_ce_i    (data_ce),
    .core_data_we_i    (data_we),
    .core_data_addr_i  (daddr),
    .core_data_wdata_i (dwdata),
    .core_inst_o       (inst_o),
    .core_data_rdata_o (rdata_o),
    .core_en_o         (en_o),
    .mem_req_o         (mem_req),
    .mem_we_o          (mem_we),
    .mem_addr_o        (mem_addr),
    .mem_wdata_o       (mem_wdata),
    .mem_gnt_i         (gnt),
    .mem_rvalid_i      (rvalid),
    .mem_rdata_i       (mem_rdata),
    .err_o             (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // One instruction, entered at the negedge of its first FETCH cycle.
  // gf/gd = grant wait cycles, rf/rd = extra rvalid wait cycles.
  task automatic do_instr(input logic [31:0] inst, input logic [31:0] da,
                          input logic [31:0] wd, input int gf, input int rf,
                          input int gd, input int rd, input logic [31:0] rval,
                          input bit abort);
    bit is_st, is_ld;
    int start, lat;
    is_st = (inst[6:0] == OPC_ST) || (inst[6:0] == OPC_BOTH);
    is_ld = !is_st && (inst[6:0] == OPC_LD);
    daddr  = da;
    dwdata = wd;
    start  = cyc;
    // fetch request, held until grant; stray rvalid must be ignored
    for (int k = 0; k <= gf; k++) begin
      chk("f_req", {31'b0, mem_req}, 32'd1);
      chk("f_addr", mem_addr, pc);
      chk("f_we", {31'b0, mem_we}, 32'd0);
      chk("f_en", {31'b0, en_o}, 32'd0);
      gnt       = (k == gf);
      rvalid    = (k < gf) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom();
      step();
    end
    gnt = 1'b0;
    // fetch response
    for (int k = 0; k <= rf; k++) begin
      chk("fw_req", {31'b0, mem_req}, 32'd0);
      chk("fw_inst_hold", inst_o, exp_inst);
      rvalid    = (k == rf);
      mem_rdata = (k == rf) ? inst : $urandom();
      step();
    end
    rvalid   = 1'b0;
    exp_inst = inst;
    chk("ex_inst", inst_o, inst);
    chk("ex_req", {31'b0, mem_req}, 32'd0);
    chk("ex_addr0", mem_addr, 32'd0);
    if (!is_st && !is_ld) begin
      chk("alu_en", {31'b0, en_o}, 32'd1);
      lat = cyc - start + 1;
      chk("alu_lat", lat, 3 + gf + rf);
      pc = pc + 32'd4;
      step();
      return;
    end
    chk("ex_en", {31'b0, en_o}, 32'd0);
    step();
    // data request, held until grant
    for (int k = 0; k <= gd; k++) begin
      chk("d_req", {31'b0, mem_req}, 32'd1);
      chk("d_addr", mem_addr, da);
      chk("d_we", {31'b0, mem_we}, {31'b0, is_st});
      chk("d_wdata", mem_wdata, wd);
      chk("d_en", {31'b0, en_o}, 32'd0);
      gnt       = (k == gd);
      rvalid    = (k < gd) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom();
      step();
    end
    gnt = 1'b0;
    rvalid = 1'b0;
    if (is_ld) begin
      for (int k = 0; k <= rd; k++) begin
        chk("dw_req", {31'b0, mem_req}, 32'd0);
        chk("dw_en", {31'b0, en_o}, 32'd0);
        if (abort) begin
          #2 rst = 1'b0;
          #1;
          chk("rst_req_drop", {31'b0, mem_req}, 32'd0);
          chk("rst_en_drop", {31'b0, en_o}, 32'd0);
          step();
          chk("rst_inst_nop", inst_o, 32'h0000_0013);
          chk("rst_rdata0", rdata_o, 32'd0);
          chk("rst_err0", {31'b0, err}, 32'd0);
          chk("rst_addr0", mem_addr, 32'd0);
          pc        = 32'h0;
          exp_inst  = 32'h0000_0013;
          exp_rdata = 32'h0;
          rst       = 1'b1;
          #1;
          chk("rel_idle_req", {31'b0, mem_req}, 32'd0);
          step();
          return;
        end
        rvalid    = (k == rd);
        mem_rdata = (k == rd) ? rval : $urandom();
        step();
      end
      rvalid    = 1'b0;
      exp_rdata = rval;
    end
    // commit: held values stable, one-cycle strobe
    chk("c_en", {31'b0, en_o}, 32'd1);
    chk("c_req", {31'b0, mem_req}, 32'd0);
    chk("c_rdata", rdata_o, exp_rdata);
    chk("c_inst", inst_o, inst);
    lat = cyc - start + 1;
    chk("c_lat", lat, (is_ld ? 6 : 5) + gf + rf + gd + (is_ld ? rd : 0));
    pc = pc + 32'd4;
    step();
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    int          kind;

    // reset held
    step();
    step();
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_en", {31'b0, en_o}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b1;
    #1;
    chk("idle_req", {31'b0, mem_req}, 32'd0);
    step();

    // directed: ADD at 0x0, LW from 0x100 with 3-cycle grant delay, SW to 0x200
    do_instr(32'h0020_81b3, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 1'b0);
    do_instr(32'h1000_2083, 32'h100, 32'h0, 0, 0, 3, 0, 32'hDEAD_BEEF, 1'b0);
    do_instr(32'h2020_2023, 32'h200, 32'h1234_5678, 0, 0, 0, 0, 32'h0, 1'b0);
    // both ce and we set: handled as a store
    do_instr({25'h1, OPC_BOTH}, 32'h300, 32'hCAFE_F00D, 1, 1, 1, 0, 32'h0, 1'b0);

    // random instruction mix and memory delays
    for (int i = 0; i < 60; i++) begin
      r    = $urandom();
      kind = $urandom_range(0, 3);
      case (kind)
        0:       opc = OPC_ALU;
        1:       opc = OPC_LD;
        2:       opc = OPC_ST;
        default: opc = OPC_BOTH;
      endcase
      do_instr({r[31:7], opc}, $urandom(), $urandom(),
               $urandom_range(0, 3), $urandom_range(0, 2),
               $urandom_range(0, 3), $urandom_range(0, 2), $urandom(), 1'b0);
    end

    // grant withheld
    for (int k = 0; k < 20; k++) begin
      chk("nogrant_req", {31'b0, mem_req}, 32'd1);
      chk("nogrant_addr", mem_addr, pc);
`ifdef MEMSEQ_TIMEOUT_EN
      chk("timeout_err", {31'b0, err}, {31'b0, (k >= TO_CYC)});
`else
      chk("nogrant_err", {31'b0, err}, 32'd0);
`endif
      gnt = 1'b0;
      step();
    end
    do_instr({25'h5, OPC_ALU}, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 1'b0);

    // reset during D_WAIT, then restart from PC 0
    do_instr({25'h7, OPC_LD}, 32'h400, 32'h0, 0, 0, 0, 1, 32'h5555_AAAA, 1'b1);
    do_instr({25'h9, OPC_ALU}, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 1'b0);
    do_instr({25'hB, OPC_LD}, 32'h500, 32'h0, 2, 2, 2, 2, 32'h0BAD_F00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
